fetch_unit: RTL and testbench
=============================

# fetch_unit

LC-3 instruction fetch stage, directly upstream of the pipeline controller. It owns the program counter and issues single-word reads to instruction memory. It returns the fetched word as `IR` together with a one-cycle `complete_instr` strobe, and applies PC updates (sequential or branch/jump redirect) when the controller asserts `enable_updatePC`. In-flight fetches made stale by a redirect are squashed, and a hung instruction memory is reported through a sticky error flag.

## Interface
Parameters:
- `RESET_PC`, 16'h3000, PC value after reset.
- `TIMEOUT`, 15, maximum cycles spent waiting for a memory response before an error is flagged (1..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable_fetch`  in  1  controller request to start a fetch at current `pc`.
- `enable_updatePC`  in  1  controller strobe to advance or redirect `pc`.
- `br_taken`  in  1  qualifies `enable_updatePC`: 1 selects `taddr`, 0 selects `npc`.
- `taddr`  in  16  branch/JMP target address.
- `IMem_dout`  in  16  instruction memory read data.
- `IMem_ack`  in  1  instruction memory response valid; `IMem_dout` is valid in the same cycle.
- `IMem_addr`  out  16  instruction memory read address (registered).
- `IMem_rd`  out  1  instruction memory read request (registered, one-cycle pulse).
- `pc`  out  16  current program counter.
- `npc`  out  16  `pc + 1`, combinational, modulo 2^16.
- `IR`  out  16  last accepted instruction word.
- `complete_instr`  out  1  one-cycle pulse: `IR` has just been loaded.
- `fetch_err`  out  1  sticky memory-timeout flag.

## Operation
- FSM states: IDLE, REQ, WAIT, FLUSH.
- **IDLE**
  - `enable_fetch`=1 → REQ; otherwise stay.
  - `enable_updatePC` is applied here and in REQ: `pc <= br_taken ? taddr : npc`.
- **REQ**
  - `IMem_rd`=1 and `IMem_addr`=`pc` for exactly this cycle.
  - Always → WAIT.
  - If `enable_updatePC` is asserted in REQ, `pc` updates and the state goes → FLUSH instead of WAIT (the issued request is stale).
- **WAIT**: a timeout counter increments each cycle.
  - `IMem_ack`=1: `IR <= IMem_dout`, `complete_instr` pulses next cycle, → IDLE. This holds even if `enable_updatePC` is asserted in the same cycle; `pc` updates as well and the response is still accepted.
  - `enable_updatePC`=1 without `IMem_ack`: `pc` updates, → FLUSH.
  - Counter reaches `TIMEOUT` with no ack: `fetch_err <= 1`, → IDLE.
- **FLUSH**: waits for the stale response.
  - `IMem_ack`=1: data discarded (`IR` unchanged, no `complete_instr`), → REQ (auto-refetch at the new `pc`).
  - Further `enable_updatePC` strobes in FLUSH update `pc` and the state stays in FLUSH.
  - Timeout applies as in WAIT: `fetch_err` set, → IDLE.
- Timeout counter: cleared on entry to WAIT or FLUSH, saturates, width `$clog2(TIMEOUT+1)`.
- `enable_fetch` is ignored outside IDLE (not queued).
- `IMem_ack` in IDLE or REQ is ignored.
- `pc` arithmetic is 16-bit wrap: 16'hFFFF + 1 = 16'h0000.
- `fetch_err` clears only on `rst`. It does not block further fetches.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `IR`=16'h0000, `IMem_addr`=16'h0000.
  - `IMem_rd`=0, `complete_instr`=0, `fetch_err`=0.
  - State IDLE, counter 0.
- `rst` asserted in any state, including mid-WAIT, returns to reset values on the next edge. A later `IMem_ack` from the aborted request arrives in IDLE and is ignored.
- Latency:
  - `enable_fetch` sampled at edge T → `IMem_rd` high in cycle T+1.
  - Zero-wait memory (ack in first WAIT cycle, T+2) → `IR` and `complete_instr` valid in cycle T+3.
  - Minimum fetch latency is 3 cycles.
  - Each memory wait cycle adds 1.
- `pc` update is visible the cycle after the `enable_updatePC` edge; `npc` follows combinationally.
- `complete_instr` is high for exactly one cycle per accepted response. There is never more than one outstanding request.

## Test plan
- **Reset and sequential fetch:** `rst`, then `enable_fetch` with ack one cycle after `IMem_rd`, `IMem_dout`=16'h1261 → `IMem_addr`=16'h3000, `IR`=16'h1261, `complete_instr` pulse at T+3. Then `enable_updatePC` with `br_taken`=0 → `pc`=16'h3001.
- **Branch redirect in IDLE:** `enable_updatePC`, `br_taken`=1, `taddr`=16'h4000 → `pc`=16'h4000, `npc`=16'h4001. Next fetch drives `IMem_addr`=16'h4000.
- **Redirect mid-WAIT:** fetch at 16'h3000, memory delays 4 cycles, redirect to 16'h5000 in cycle 2 of WAIT → stale 16'hDEAD discarded (`IR` unchanged, no `complete_instr`), automatic `IMem_rd` at 16'h5000, its data loaded into `IR`.
- **Simultaneous ack and redirect in WAIT:** response accepted into `IR` with `complete_instr`=1, `pc`=`taddr`, no refetch.
- **Timeout:** `TIMEOUT`=15, no ack → `fetch_err`=1 after 15 WAIT cycles, FSM back in IDLE. A late ack is ignored, `fetch_err` stays 1 until `rst`.
- **Wrap:** `taddr`=16'hFFFF redirect, then sequential `enable_updatePC` → `pc`=16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// LC-3 instruction fetch stage: owns the PC, issues single-word reads to
// instruction memory, squashes stale responses after a redirect, flags hung memory.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_fetch,
    input  logic        enable_updatePC,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    input  logic [15:0] IMem_dout,
    input  logic        IMem_ack,
    output logic [15:0] IMem_addr,
    output logic        IMem_rd,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic [15:0] IR,
    output logic        complete_instr,
    output logic        fetch_err
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [15:0]   pc_n;
    logic          load_ir, set_err, tmo, waiting, entering_wait;

    assign npc           = pc + 16'd1;
    assign tmo           = (cnt == TMO_LAST);
    assign waiting       = (state == S_WAIT) || (state == S_FLUSH);
    assign entering_wait = ((state_n == S_WAIT) || (state_n == S_FLUSH)) && (state_n != state);

    always_comb begin
        state_n = state;
        load_ir = 1'b0;
        set_err = 1'b0;
        pc_n    = enable_updatePC ? (br_taken ? taddr : npc) : pc;
        case (state)
            S_IDLE: if (enable_fetch) state_n = S_REQ;
            // A redirect while the request is on the bus makes it stale.
            S_REQ:  state_n = enable_updatePC ? S_FLUSH : S_WAIT;
            S_WAIT: begin
                if (IMem_ack) begin
                    load_ir = 1'b1;
                    state_n = S_IDLE;
                end else if (enable_updatePC) begin
                    state_n = S_FLUSH;
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_FLUSH: begin
                // Stale data dropped; refetch at whatever pc is now.
                if (IMem_ack) begin
                    state_n = S_REQ;
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            pc             <= RESET_PC;
            IR             <= 16'h0000;
            IMem_addr      <= 16'h0000;
            IMem_rd        <= 1'b0;
            complete_instr <= 1'b0;
            fetch_err      <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            IMem_rd        <= (state_n == S_REQ);
            complete_instr <= load_ir;
            if (state_n == S_REQ) IMem_addr <= pc_n;
            if (load_ir)          IR        <= IMem_dout;
            if (set_err)          fetch_err <= 1'b1;
            if (entering_wait)
                cnt <= '0;
            else if (waiting && cnt != TMO_MAX)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, enable_fetch, enable_updatePC, br_taken, IMem_ack;
    logic [15:0] taddr, IMem_dout;
    logic [15:0] IMem_addr, pc, npc, IR;
    logic        IMem_rd, complete_instr, fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h3000), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .enable_fetch(enable_fetch),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken), .taddr(taddr),
        .IMem_dout(IMem_dout), .IMem_ack(IMem_ack), .IMem_addr(IMem_addr),
        .IMem_rd(IMem_rd), .pc(pc), .npc(npc), .IR(IR),
        .complete_instr(complete_instr), .fetch_err(fetch_err)
    );

    // Inputs applied for one cycle; expected outputs seen after that edge.
    typedef struct {
        logic        rst, ef, upd, br, ack;
        logic [15:0] taddr, dout;
        logic [15:0] e_pc, e_npc, e_ir, e_addr;
        logic        e_rd, e_ci, e_err;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic r, input logic ef, input logic upd, input logic br,
                         input logic [15:0] ta, input logic ack, input logic [15:0] dout);
        rst = r; enable_fetch = ef; enable_updatePC = upd; br_taken = br;
        taddr = ta; IMem_ack = ack; IMem_dout = dout;
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        vt[0]  = '{1,0,0,0,0, 16'h0000,16'h0000, 16'h3000,16'h3001,16'h0000,16'h0000, 0,0,0};
        vt[1]  = '{0,1,0,0,0, 16'h0000,16'h0000, 16'h3000,16'h3001,16'h0000,16'h3000, 1,0,0};
        vt[2]  = '{0,0,0,0,0, 16'h0000,16'h0000, 16'h3000,16'h3001,16'h0000,16'h3000, 0,0,0};
        vt[3]  = '{0,0,0,0,1, 16'h0000,16'h1261, 16'h3000,16'h3001,16'h1261,16'h3000, 0,1,0};
        vt[4]  = '{0,0,1,0,0, 16'h0000,16'h0000, 16'h3001,16'h3002,16'h1261,16'h3000, 0,0,0};
        vt[5]  = '{0,0,1,1,0, 16'h4000,16'h0000, 16'h4000,16'h4001,16'h1261,16'h3000, 0,0,0};
        vt[6]  = '{0,1,0,0,0, 16'h0000,16'h0000, 16'h4000,16'h4001,16'h1261,16'h4000, 1,0,0};
        vt[7]  = '{0,0,0,0,0, 16'h0000,16'h0000, 16'h4000,16'h4001,16'h1261,16'h4000, 0,0,0};
        vt[8]  = '{0,0,1,1,1, 16'h6000,16'h5A5A, 16'h6000,16'h6001,16'h5A5A,16'h4000, 0,1,0};
        vt[9]  = '{0,0,0,0,0, 16'h0000,16'h0000, 16'h6000,16'h6001,16'h5A5A,16'h4000, 0,0,0};
        vt[10] = '{0,0,1,1,0, 16'hFFFF,16'h0000, 16'hFFFF,16'h0000,16'h5A5A,16'h4000, 0,0,0};
        vt[11] = '{0,0,1,0,0, 16'h0000,16'h0000, 16'h0000,16'h0001,16'h5A5A,16'h4000, 0,0,0};
        vt[12] = '{0,0,0,0,1, 16'h0000,16'h1111, 16'h0000,16'h0001,16'h5A5A,16'h4000, 0,0,0};

        rst = 1; enable_fetch = 0; enable_updatePC = 0; br_taken = 0;
        taddr = 0; IMem_ack = 0; IMem_dout = 0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rst, vt[i].ef, vt[i].upd, vt[i].br, vt[i].taddr, vt[i].ack, vt[i].dout);
            chk($sformatf("v%0d pc", i),   pc,               vt[i].e_pc);
            chk($sformatf("v%0d npc", i),  npc,              vt[i].e_npc);
            chk($sformatf("v%0d IR", i),   IR,               vt[i].e_ir);
            chk($sformatf("v%0d addr", i), IMem_addr,        vt[i].e_addr);
            chk($sformatf("v%0d rd", i),   16'(IMem_rd),     16'(vt[i].e_rd));
            chk($sformatf("v%0d ci", i),   16'(complete_instr), 16'(vt[i].e_ci));
            chk($sformatf("v%0d err", i),  16'(fetch_err),   16'(vt[i].e_err));
        end

        // Redirect in the second WAIT cycle; stale DEAD dropped, refetch at 5000.
        drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
        chk("rw req rd", 16'(IMem_rd), 16'd1);
        idle_cyc();
        idle_cyc();
        drive(0, 0, 1, 1, 16'h5000, 0, 16'h0);
        chk("rw pc", pc, 16'h5000);
        chk("rw no rd", 16'(IMem_rd), 16'd0);
        idle_cyc();
        drive(0, 0, 0, 0, 16'h0, 1, 16'hDEAD);
        chk("rw stale IR", IR, 16'h0000);
        chk("rw stale ci", 16'(complete_instr), 16'd0);
        chk("rw refetch rd", 16'(IMem_rd), 16'd1);
        chk("rw refetch addr", IMem_addr, 16'h5000);
        idle_cyc();
        drive(0, 0, 0, 0, 16'h0, 1, 16'h2345);
        chk("rw IR", IR, 16'h2345);
        chk("rw ci", 16'(complete_instr), 16'd1);
        idle_cyc();
        chk("rw ci pulse", 16'(complete_instr), 16'd0);

        // Timeout: 15 WAIT cycles without ack, then a late ack is ignored.
        drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
        idle_cyc();
        for (int i = 0; i < 14; i++) idle_cyc();
        chk("to err early", 16'(fetch_err), 16'd0);
        idle_cyc();
        chk("to err set", 16'(fetch_err), 16'd1);
        drive(0, 0, 0, 0, 16'h0, 1, 16'hBEEF);
        chk("to late IR", IR, 16'h0000);
        chk("to late ci", 16'(complete_instr), 16'd0);
        chk("to err sticky", 16'(fetch_err), 16'd1);
        drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
        chk("to fetch after err", 16'(IMem_rd), 16'd1);
        drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
        chk("to err cleared", 16'(fetch_err), 16'd0);

        // Reset mid-WAIT; the aborted request's ack lands in IDLE and is ignored.
        drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
        idle_cyc();
        drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
        drive(0, 0, 0, 0, 16'h0, 1, 16'h7777);
        chk("rst ack IR", IR, 16'h0000);
        chk("rst ack ci", 16'(complete_instr), 16'd0);
        chk("rst ack rd", 16'(IMem_rd), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
